branch_cache_update_ctrl: RTL and testbench

- Scheduler for the branch cache's single jump-update port.
- Collects resolved-branch results from two execute pipes (EXE0 = older, EXE1 = younger) and buffers them in a small in-order FIFO.
- Issues at most one update per cycle to the cache, deferring an update whose set index collides with a same-cycle cache search.
- Sequences a cache flush, dropping all pending updates.

---
 rtl/branch_cache_update_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_branch_cache_update_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cache_update_ctrl.sv
// ---------------------------------------------------------------------------
// branch_cache_update_ctrl
//
// Schedules updates for the branch cache's single jump-update port. Resolved
// branches from two execute pipes (EXE0 = older, EXE1 = younger) go into a
// small in-order FIFO. At most one entry is issued per cycle. An entry whose
// set index matches a same-cycle cache search is held back, but only for
// STALL_LIMIT cycles in a row; after that it is issued anyway. A flush drops
// every pending entry and sends a one-cycle (or level) flush to the cache.
//
// Handshake (EXE pipes): a request is accepted at a rising clock edge when
// VALID=1 and LOCK=0 in that cycle and no flush is requested. While LOCK=1
// the pipe holds VALID and its payload stable. A request presented together
// with iFLUSH=1 and LOCK=0 is discarded. LOCK depends only on registered
// state, never on VALID.
//
// Ports:
//   iCLOCK, inRESET          clock, asynchronous active-low reset
//   iFLUSH                   flush request (pulse or level)
//   iEXEx_VALID/HIT/ADDR/INST_ADDR, oEXEx_LOCK   resolved-branch input, x=0,1
//   iSEARCH_STB, iSEARCH_INST_ADDR               snooped cache search
//   oJUMP_STB/HIT/ADDR/INST_ADDR                 cache update (registered)
//   oCACHE_FLUSH             registered flush to the cache
//   oBUSY                    registered: entries pending or update issued
//   oDEBUG_STATE             current FSM state (0=RUN, 1=FLUSH)
// ---------------------------------------------------------------------------
module branch_cache_update_ctrl #(
  parameter int FIFO_DEPTH   = 4,
  parameter int FIFO_DEPTH_N = 2,
  parameter int STALL_LIMIT  = 3
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iFLUSH,
  input  logic        iEXE0_VALID,
  input  logic        iEXE0_HIT,
  input  logic [31:0] iEXE0_ADDR,
  input  logic [31:0] iEXE0_INST_ADDR,
  output logic        oEXE0_LOCK,
  input  logic        iEXE1_VALID,
  input  logic        iEXE1_HIT,
  input  logic [31:0] iEXE1_ADDR,
  input  logic [31:0] iEXE1_INST_ADDR,
  output logic        oEXE1_LOCK,
  input  logic        iSEARCH_STB,
  input  logic [31:0] iSEARCH_INST_ADDR,
  output logic        oJUMP_STB,
  output logic        oJUMP_HIT,
  output logic [31:0] oJUMP_ADDR,
  output logic [31:0] oJUMP_INST_ADDR,
  output logic        oCACHE_FLUSH,
  output logic        oBUSY,
  output logic        oDEBUG_STATE
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Lock one entry early: both pipes may enqueue in the same cycle, so at
  // count == FIFO_DEPTH-2 two writes still fit, at FIFO_DEPTH-1 they do not.
  localparam logic [FIFO_DEPTH_N:0] LOCK_LEVEL = (FIFO_DEPTH_N+1)'(FIFO_DEPTH - 1);
  localparam logic [3:0]            STALL_MAX  = 4'(STALL_LIMIT);

  state_t                  state, state_next;
  logic [FIFO_DEPTH_N:0]   count, count_next;
  logic [FIFO_DEPTH_N-1:0] wr_ptr, wr_ptr_next, wr_slot1;
  logic [FIFO_DEPTH_N-1:0] rd_ptr, rd_ptr_next;
  logic [3:0]              stall_cnt, stall_next;

  // Entry layout: {hit, addr[31:0], inst_addr[31:0]}.
  logic [64:0] mem [FIFO_DEPTH];
  logic [64:0] head;
  logic [64:0] entry0, entry1;

  logic lock, accept, enq0, enq1;
  logic head_valid, conflict, deq, busy_next;

  // Only the set index [4:2] of the search address takes part in the check.
  logic unused_search_bits;
  assign unused_search_bits = ^{iSEARCH_INST_ADDR[31:5], iSEARCH_INST_ADDR[1:0]};

  assign entry0 = {iEXE0_HIT, iEXE0_ADDR, iEXE0_INST_ADDR};
  assign entry1 = {iEXE1_HIT, iEXE1_ADDR, iEXE1_INST_ADDR};

  assign oEXE0_LOCK   = lock;
  assign oEXE1_LOCK   = lock;
  assign oDEBUG_STATE = (state == ST_FLUSH);

  // Next-state / datapath control.
  always_comb begin
    state_next  = ST_RUN;
    lock        = 1'b0;
    accept      = 1'b0;
    enq0        = 1'b0;
    enq1        = 1'b0;
    head        = mem[rd_ptr];
    head_valid  = 1'b0;
    conflict    = 1'b0;
    deq         = 1'b0;
    stall_next  = stall_cnt;
    count_next  = count;
    wr_ptr_next = wr_ptr;
    wr_slot1    = wr_ptr;
    rd_ptr_next = rd_ptr;
    busy_next   = 1'b0;

    // FLUSH always lasts one cycle; a held iFLUSH simply re-enters it.
    if (iFLUSH) begin
      state_next = ST_FLUSH;
    end

    lock   = (state == ST_FLUSH) || (count >= LOCK_LEVEL);
    accept = (state == ST_RUN) && !iFLUSH && !lock;
    enq0   = accept && iEXE0_VALID;
    enq1   = accept && iEXE1_VALID;

    // Dequeue looks at the registered head only, so an entry written at an
    // edge becomes issuable from the following cycle.
    head_valid = (state == ST_RUN) && !iFLUSH && (count != '0);
    conflict   = iSEARCH_STB && (iSEARCH_INST_ADDR[4:2] == head[4:2]);
    deq        = head_valid && (!conflict || (stall_cnt == STALL_MAX));

    if (iFLUSH || deq) begin
      stall_next = 4'd0;
    end else if (head_valid && conflict) begin
      stall_next = stall_cnt + 4'd1;
    end

    // EXE1 lands behind EXE0 when both are written in the same cycle.
    wr_slot1 = enq0 ? (wr_ptr + FIFO_DEPTH_N'(1)) : wr_ptr;

    if (iFLUSH) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      count_next  = count + (FIFO_DEPTH_N+1)'(enq0) + (FIFO_DEPTH_N+1)'(enq1)
                          - (FIFO_DEPTH_N+1)'(deq);
      wr_ptr_next = wr_ptr + FIFO_DEPTH_N'(enq0) + FIFO_DEPTH_N'(enq1);
      rd_ptr_next = rd_ptr + FIFO_DEPTH_N'(deq);
    end

    busy_next = (count_next != '0) || deq;
  end

  // Queue storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge iCLOCK) begin
    if (enq0) begin
      mem[wr_ptr] <= entry0;
    end
    if (enq1) begin
      mem[wr_slot1] <= entry1;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state           <= ST_RUN;
      count           <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      stall_cnt       <= 4'd0;
      oJUMP_STB       <= 1'b0;
      oJUMP_HIT       <= 1'b0;
      oJUMP_ADDR      <= 32'd0;
      oJUMP_INST_ADDR <= 32'd0;
      oCACHE_FLUSH    <= 1'b0;
      oBUSY           <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      wr_ptr       <= wr_ptr_next;
      rd_ptr       <= rd_ptr_next;
      stall_cnt    <= stall_next;
      oJUMP_STB    <= deq;
      oCACHE_FLUSH <= iFLUSH;
      oBUSY        <= busy_next;
      // Payload holds the last issued entry between strobes.
      if (deq) begin
        {oJUMP_HIT, oJUMP_ADDR, oJUMP_INST_ADDR} <= head;
      end
    end
  end

endmodule

// File: tb/tb_branch_cache_update_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for branch_cache_update_ctrl.
// Reference model: a queue of pending entries, a deferral count and a flag
// for the one-cycle flush state, advanced once per clock edge from the
// inputs being driven. Issued entries go to exp_q; per-cycle expectations
// (strobe, locks, flush, busy, held payload) go to stat_q. A monitor on the
// falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_branch_cache_update_ctrl;

  localparam int FIFO_DEPTH   = 4;
  localparam int FIFO_DEPTH_N = 2;
  localparam int STALL_LIMIT  = 3;

  // ---- clock / reset / DUT -------------------------------------------------
  logic        iCLOCK;
  logic        inRESET;
  logic        iFLUSH;
  logic        iEXE0_VALID, iEXE0_HIT;
  logic [31:0] iEXE0_ADDR, iEXE0_INST_ADDR;
  logic        oEXE0_LOCK;
  logic        iEXE1_VALID, iEXE1_HIT;
  logic [31:0] iEXE1_ADDR, iEXE1_INST_ADDR;
  logic        oEXE1_LOCK;
  logic        iSEARCH_STB;
  logic [31:0] iSEARCH_INST_ADDR;
  logic        oJUMP_STB, oJUMP_HIT;
  logic [31:0] oJUMP_ADDR, oJUMP_INST_ADDR;
  logic        oCACHE_FLUSH, oBUSY, oDEBUG_STATE;

  initial begin
    iCLOCK = 1'b0;
    forever #5 iCLOCK = ~iCLOCK;
  end

  branch_cache_update_ctrl #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .FIFO_DEPTH_N(FIFO_DEPTH_N),
    .STALL_LIMIT (STALL_LIMIT)
  ) dut (
    .iCLOCK           (iCLOCK),
    .inRESET          (inRESET),
    .iFLUSH           (iFLUSH),
    .iEXE0_VALID      (iEXE0_VALID),
    .iEXE0_HIT        (iEXE0_HIT),
    .iEXE0_ADDR       (iEXE0_ADDR),
    .iEXE0_INST_ADDR  (iEXE0_INST_ADDR),
    .oEXE0_LOCK       (oEXE0_LOCK),
    .iEXE1_VALID      (iEXE1_VALID),
    .iEXE1_HIT        (iEXE1_HIT),
    .iEXE1_ADDR       (iEXE1_ADDR),
    .iEXE1_INST_ADDR  (iEXE1_INST_ADDR),
    .oEXE1_LOCK       (oEXE1_LOCK),
    .iSEARCH_STB      (iSEARCH_STB),
    .iSEARCH_INST_ADDR(iSEARCH_INST_ADDR),
    .oJUMP_STB        (oJUMP_STB),
    .oJUMP_HIT        (oJUMP_HIT),
    .oJUMP_ADDR       (oJUMP_ADDR),
    .oJUMP_INST_ADDR  (oJUMP_INST_ADDR),
    .oCACHE_FLUSH     (oCACHE_FLUSH),
    .oBUSY            (oBUSY),
    .oDEBUG_STATE     (oDEBUG_STATE)
  );

  // ---- scoreboard state ------------------------------------------------------
  typedef struct {
    logic        stb;
    logic        lock;
    logic        cflush;
    logic        busy;
    logic        dbg;
    logic [64:0] last;
  } stat_t;

  logic [64:0] exp_q[$];
  stat_t       stat_q[$];
  int          checks   = 0;
  int          failures = 0;
  bit          mon_en   = 1'b0;

  // Reference model state.
  logic [64:0] mq[$];
  int          mstall    = 0;
  bit          mflush_st = 1'b0;
  logic [64:0] mlast     = '0;

  // Held random requests per pipe.
  bit          p0_v = 1'b0, p1_v = 1'b0;
  logic        p0_h, p1_h;
  logic [31:0] p0_a, p0_i, p1_a, p1_i;
  logic        d0, d1;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---- monitor ---------------------------------------------------------------
  stat_t ms;
  always @(negedge iCLOCK) begin
    if (mon_en && stat_q.size() > 0) begin
      ms = stat_q.pop_front();
      chk("jump_stb",     72'(oJUMP_STB),    72'(ms.stb));
      chk("exe0_lock",    72'(oEXE0_LOCK),   72'(ms.lock));
      chk("exe1_lock",    72'(oEXE1_LOCK),   72'(ms.lock));
      chk("cache_flush",  72'(oCACHE_FLUSH), 72'(ms.cflush));
      chk("busy",         72'(oBUSY),        72'(ms.busy));
      chk("debug_state",  72'(oDEBUG_STATE), 72'(ms.dbg));
      chk("jump_payload", 72'({oJUMP_HIT, oJUMP_ADDR, oJUMP_INST_ADDR}), 72'(ms.last));
      if (oJUMP_STB) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_issue actual=%h expected=none t=%0t",
                   {oJUMP_HIT, oJUMP_ADDR, oJUMP_INST_ADDR}, $time);
        end else begin
          chk("issue_entry", 72'({oJUMP_HIT, oJUMP_ADDR, oJUMP_INST_ADDR}),
              72'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---- driver: drive one cycle of inputs and advance the model ----------------
  task automatic step(
    input  logic v0, input logic h0, input logic [31:0] a0, input logic [31:0] i0,
    input  logic v1, input logic h1, input logic [31:0] a1, input logic [31:0] i1,
    input  logic sstb, input logic [31:0] saddr, input logic fl,
    output logic took0, output logic took1);
    logic        lk, stb, conflict;
    logic [64:0] hd;
    stat_t       s;
    iEXE0_VALID = v0; iEXE0_HIT = h0; iEXE0_ADDR = a0; iEXE0_INST_ADDR = i0;
    iEXE1_VALID = v1; iEXE1_HIT = h1; iEXE1_ADDR = a1; iEXE1_INST_ADDR = i1;
    iSEARCH_STB = sstb; iSEARCH_INST_ADDR = saddr; iFLUSH = fl;

    lk    = mflush_st || (mq.size() >= FIFO_DEPTH - 1);
    took0 = v0 && !lk;   // consumed: queued, or dropped by a flush
    took1 = v1 && !lk;
    stb   = 1'b0;
    if (fl) begin
      mq.delete();
      mstall    = 0;
      mflush_st = 1'b1;
    end else if (mflush_st) begin
      mflush_st = 1'b0;
    end else begin
      if (mq.size() > 0) begin
        hd       = mq[0];
        conflict = sstb && (saddr[4:2] == hd[4:2]);
        if (!conflict || mstall == STALL_LIMIT) begin
          hd     = mq.pop_front();
          mlast  = hd;
          exp_q.push_back(hd);
          stb    = 1'b1;
          mstall = 0;
        end else begin
          mstall++;
        end
      end
      if (took0) mq.push_back({h0, a0, i0});
      if (took1) mq.push_back({h1, a1, i1});
    end
    s.stb    = stb;
    s.lock   = mflush_st || (mq.size() >= FIFO_DEPTH - 1);
    s.cflush = fl;
    s.busy   = (mq.size() > 0) || stb;
    s.dbg    = mflush_st;
    s.last   = mlast;
    stat_q.push_back(s);
  endtask

  task automatic tick();
    @(negedge iCLOCK);
    #2;
  endtask

  task automatic idle(input int n, input logic sstb, input logic [31:0] saddr);
    for (int k = 0; k < n; k++) begin
      tick();
      step(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, sstb, saddr, 0, d0, d1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_jump_stb"},   72'(oJUMP_STB),       72'd0);
    chk({tag, "_jump_hit"},   72'(oJUMP_HIT),       72'd0);
    chk({tag, "_jump_addr"},  72'(oJUMP_ADDR),      72'd0);
    chk({tag, "_jump_iaddr"}, 72'(oJUMP_INST_ADDR), 72'd0);
    chk({tag, "_cflush"},     72'(oCACHE_FLUSH),    72'd0);
    chk({tag, "_busy"},       72'(oBUSY),           72'd0);
    chk({tag, "_lock0"},      72'(oEXE0_LOCK),      72'd0);
    chk({tag, "_lock1"},      72'(oEXE1_LOCK),      72'd0);
    chk({tag, "_dbg"},        72'(oDEBUG_STATE),    72'd0);
  endtask

  // Assert reset between edges, check outputs at once, release mid-cycle.
  task automatic do_reset();
    @(negedge iCLOCK);
    #2;
    mon_en = 1'b0;
    iEXE0_VALID = 0; iEXE1_VALID = 0; iSEARCH_STB = 0; iFLUSH = 0;
    inRESET = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    mq.delete(); exp_q.delete(); stat_q.delete();
    mstall = 0; mflush_st = 1'b0; mlast = '0;
    p0_v = 1'b0; p1_v = 1'b0;
    @(negedge iCLOCK);
    @(negedge iCLOCK);
    #2;
    inRESET = 1'b1;
    mon_en  = 1'b1;
    step(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0, 32'd0, 0, d0, d1);
  endtask

  task automatic rand_cycle(input int pv, input int pconf, input int pflush);
    logic        sstb, fl, t0, t1;
    logic [31:0] saddr;
    if (!p0_v && $urandom_range(99) < pv) begin
      p0_v = 1'b1; p0_h = 1'($urandom); p0_a = $urandom; p0_i = $urandom;
      p0_i[4:2] = 3'($urandom_range(5, 4));
    end
    if (!p1_v && $urandom_range(99) < pv) begin
      p1_v = 1'b1; p1_h = 1'($urandom); p1_a = $urandom; p1_i = $urandom;
      p1_i[4:2] = 3'($urandom_range(5, 4));
    end
    sstb  = ($urandom_range(99) < pconf);
    saddr = $urandom;
    saddr[4:2] = 3'($urandom_range(5, 4));
    fl    = ($urandom_range(99) < pflush);
    tick();
    step(p0_v, p0_h, p0_a, p0_i, p1_v, p1_h, p1_a, p1_i, sstb, saddr, fl, t0, t1);
    if (t0) p0_v = 1'b0;
    if (t1) p1_v = 1'b0;
  endtask

  // ---- main sequence ----------------------------------------------------------
  int pv_tab[4]     = '{30, 70, 90, 50};
  int pconf_tab[4]  = '{20, 60, 90, 40};
  int pflush_tab[4] = '{0, 2, 5, 1};
  bit got;

  initial begin
    inRESET = 1'b1;
    iFLUSH = 0; iEXE0_VALID = 0; iEXE0_HIT = 0; iEXE0_ADDR = 0; iEXE0_INST_ADDR = 0;
    iEXE1_VALID = 0; iEXE1_HIT = 0; iEXE1_ADDR = 0; iEXE1_INST_ADDR = 0;
    iSEARCH_STB = 0; iSEARCH_INST_ADDR = 0;
    #1 inRESET = 1'b0;
    #11;
    check_reset_outputs("reset");
    @(negedge iCLOCK);
    #2;
    inRESET = 1'b1;
    mon_en  = 1'b1;
    step(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0, 32'd0, 0, d0, d1);

    // Single update with two-cycle latency.
    tick();
    step(1, 1, 32'h0000_1000, 32'h0000_0024, 0, 0, 32'd0, 32'd0, 0, 32'd0, 0, d0, d1);
    idle(4, 0, 32'd0);

    // Same-edge pair: EXE0 issues before EXE1.
    tick();
    step(1, 0, 32'h0000_2000, 32'h0000_0040, 1, 1, 32'h0000_3000, 32'h0000_0080,
         0, 32'd0, 0, d0, d1);
    idle(4, 0, 32'd0);

    // Conflicting search every cycle: three deferrals, forced issue on the fourth.
    tick();
    step(1, 1, 32'h0000_4000, 32'h0000_0014, 0, 0, 32'd0, 32'd0, 1, 32'h0000_1234, 0, d0, d1);
    idle(6, 1, 32'h0000_1234);
    // Different set: no deferral.
    tick();
    step(1, 0, 32'h0000_4100, 32'h0000_0018, 0, 0, 32'd0, 32'd0, 1, 32'h0000_1234, 0, d0, d1);
    idle(3, 1, 32'h0000_1234);
    idle(2, 0, 32'd0);

    // Fill to the lock level while the head is deferred; EXE1 waits for a pop.
    for (int k = 0; k < 3; k++) begin
      tick();
      step(1, 1'(k), 32'(32'h0000_5000 + k), 32'(32'h0000_0114 + (k << 8)),
           0, 0, 32'd0, 32'd0, 1, 32'h0000_1234, 0, d0, d1);
    end
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      tick();
      step(0, 0, 32'd0, 32'd0, 1, 1, 32'h0000_5100, 32'h0000_0414,
           1, 32'h0000_1234, 0, d0, d1);
      got = d1;
    end
    chk("lock_release", 72'(got), 72'd1);
    idle(8, 0, 32'd0);

    // Flush with three entries queued and an EXE0 request in the same cycle.
    for (int k = 0; k < 3; k++) begin
      tick();
      step(1, 0, 32'(32'h0000_6000 + k), 32'(32'h0000_0014 + (k << 8)),
           0, 0, 32'd0, 32'd0, 1, 32'h0000_1234, 0, d0, d1);
    end
    tick();
    step(1, 1, 32'h0000_7000, 32'h0000_0030, 0, 0, 32'd0, 32'd0,
         1, 32'h0000_1234, 1, d0, d1);
    idle(5, 0, 32'd0);

    // Async reset with two entries pending, then normal latency again.
    for (int k = 0; k < 2; k++) begin
      tick();
      step(1, 1, 32'(32'h0000_8000 + k), 32'(32'h0000_0014 + (k << 8)),
           0, 0, 32'd0, 32'd0, 1, 32'h0000_1234, 0, d0, d1);
    end
    do_reset();
    tick();
    step(1, 0, 32'h0000_9000, 32'h0000_0028, 0, 0, 32'd0, 32'd0, 0, 32'd0, 0, d0, d1);
    idle(4, 0, 32'd0);

    // Randomized phases with different load, conflict and flush rates.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 600; c++) begin
        if (ph == 2 && c == 300) do_reset();
        else rand_cycle(pv_tab[ph], pconf_tab[ph], pflush_tab[ph]);
      end
    end

    // Drain: stop new requests, let held ones go in, then empty the queue.
    for (int c = 0; c < 10; c++) rand_cycle(0, 0, 0);
    idle(12, 0, 32'd0);
    @(negedge iCLOCK);
    #1;
    chk("leftover_issues", 72'(exp_q.size()), 72'd0);
    chk("final_busy", 72'(oBUSY), 72'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
